// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard/stall controller.
//   md_state_e : multiply/divide interlock state (RUN, MD_BUSY)
//   REG_ZERO   : architectural $0, never a real dependency
//   NOP_INSTR  : encoding loaded into IF/ID when ifid_flush is asserted
package pipe_hazard_ctrl_pkg;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  localparam logic [4:0]  REG_ZERO  = 5'd0;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for pipeline performance statistics.
// Ports:
//   clk   : clock
//   rst   : asynchronous active-high reset, clears the count
//   inc   : increment request for this cycle
//   count : current value, sticks at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stall controller for the 5-stage pipeline.
// Resolves, in fixed priority, data-memory wait, taken branch/jump,
// multiply/divide busy interlock and load-use, and counts stall and
// flush cycles.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   id_rs/id_rt           : source register fields of the ID instruction
//   id_use_rs/id_use_rt   : ID instruction actually reads rs/rt
//   id_is_md              : ID instruction is mult/multu/div/divu
//   id_reads_hilo         : ID instruction is mfhi/mflo
//   ex_mem_read, ex_rd    : EX instruction is a load, and its destination
//   br_taken              : branch/jump resolved taken in EX
//   dmem_busy             : data memory access still outstanding
//   pc_we, ifid_we        : front-end write enables
//   ifid_flush            : load IF/ID with NOP_INSTR
//   idex_flush            : bubble into ID/EX
//   pipe_hold             : freeze ID/EX, EX/MEM, MEM/WB
//   md_start, md_busy     : MD unit issue pulse and busy state
//   stall_cycles          : saturating count of cycles with pc_we=0
//   flush_count           : saturating count of cycles with ifid_flush=1
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MD_LAT = 4,   // legal range 2..15
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_is_md,
  input  logic             id_reads_hilo,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             br_taken,
  input  logic             dmem_busy,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             pipe_hold,
  output logic             md_start,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [3:0] MD_CNT_INIT = 4'(MD_LAT - 1);

  md_state_e  st_q, st_d;
  logic [3:0] md_cnt_q, md_cnt_d;

  logic load_use;
  logic md_hz;

  assign load_use = ex_mem_read && (ex_rd != REG_ZERO) &&
                    ((id_use_rs && (id_rs == ex_rd)) ||
                     (id_use_rt && (id_rt == ex_rd)));

  assign md_hz = (st_q == MD_BUSY) && (id_is_md || id_reads_hilo);

  // Control outputs. Everything is forced low while reset is asserted so
  // nothing, in particular md_start, leaks out in the reset cycle.
  always_comb begin
    pc_we      = 1'b0;
    ifid_we    = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    pipe_hold  = 1'b0;
    md_start   = 1'b0;
    if (!rst) begin
      if (dmem_busy) begin
        // Whole pipe frozen; a taken branch stays in EX and is acted on
        // once the memory access completes.
        pipe_hold = 1'b1;
      end else if (br_taken) begin
        pc_we      = 1'b1;
        ifid_we    = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (md_hz || load_use) begin
        idex_flush = 1'b1;
      end else begin
        pc_we    = 1'b1;
        ifid_we  = 1'b1;
        md_start = id_is_md && (st_q == RUN);
      end
    end
  end

  assign md_busy = (st_q == MD_BUSY);

  // MD interlock: the unit runs independently of the pipeline, so the
  // countdown continues through data-memory waits.
  always_comb begin
    st_d     = st_q;
    md_cnt_d = md_cnt_q;
    case (st_q)
      RUN: begin
        if (md_start) begin
          st_d     = MD_BUSY;
          md_cnt_d = MD_CNT_INIT;
        end
      end
      MD_BUSY: begin
        if (md_cnt_q == 4'd0) begin
          st_d = RUN;
        end else begin
          md_cnt_d = md_cnt_q - 4'd1;
        end
      end
      default: begin
        st_d     = RUN;
        md_cnt_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q     <= RUN;
      md_cnt_q <= 4'd0;
    end else begin
      st_q     <= st_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (!pc_we),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (ifid_flush),
    .count (flush_count)
  );

endmodule
